// File: rtl/seg7_disp_arbiter.sv
// -----------------------------------------------------------------------------
// seg7_disp_arbiter
//
// Up to four requesters share one 8-digit seven-segment display. Requesters
// might be debug counters, camera status or error codes. Grants rotate
// round-robin, and each grant lasts a minimum number of cycles. The winner's
// 32-bit hex word is registered onto dig_o. A leading-zero blank mask is
// registered onto blank_o in the same cycle, so the two stay aligned.
//
// Parameters
//   NREQ      number of requesters, 1..4
//   HOLD_CYC  minimum display cycles per grant
//   CW        hold counter width, must be able to hold HOLD_CYC-1
//
// Ports
//   clk_i    in   1        system clock, rising edge
//   rst_ni   in   1        asynchronous active-low reset
//   req_i    in   NREQ     per-requester display request (level)
//   data_i   in   32*NREQ  requester k word at [32k+31:32k], digit 0 = [3:0]
//   lzb_i    in   1        1 = enable leading-zero blanking
//   ack_o    out  NREQ     one-cycle pulse when a requester is granted
//   owner_o  out  2        index of the current/last owner
//   valid_o  out  1        1 once any word has been displayed since reset
//   dig_o    out  32       hex word to the display decoder
//   blank_o  out  8        1 = digit k dark
// -----------------------------------------------------------------------------
module seg7_disp_arbiter #(
  parameter int NREQ     = 2,
  parameter int HOLD_CYC = 50000000,
  parameter int CW       = 26
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_i,
  input  logic [32*NREQ-1:0]   data_i,
  input  logic                 lzb_i,
  output logic [NREQ-1:0]      ack_o,
  output logic [1:0]           owner_o,
  output logic                 valid_o,
  output logic [31:0]          dig_o,
  output logic [7:0]           blank_o
);

  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYC - 1);
  localparam logic [1:0]    LAST_IDX = 2'(NREQ - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      rr_q, rr_d;
  logic [1:0]      owner_q, owner_d;
  logic [31:0]     dig_q, dig_d;
  logic [7:0]      blank_q, blank_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            valid_q, valid_d;

  // Pad the request and data vectors to four slots. This lets all indexing
  // below use a plain 2-bit owner index for every legal NREQ. Slots at or
  // above NREQ are tied off, so they can never win.
  logic [3:0]  req_ext;
  logic [31:0] word [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      if (gi < NREQ) begin : g_live
        assign req_ext[gi] = req_i[gi];
        assign word[gi]    = data_i[32*gi +: 32];
      end else begin : g_pad
        assign req_ext[gi] = 1'b0;
        assign word[gi]    = 32'h0;
      end
    end
  endgenerate

  // Round-robin pick: return the first set bit of mask at or after ptr,
  // wrapping modulo NREQ. The result is {found, index}. The loop runs
  // downward, so the smallest offset from ptr is the last write and wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] mask,
                                         input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = 2'((int'(ptr) + i) % NREQ);
      if (mask[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

  logic       hold_done;
  logic       owner_req;
  logic [1:0] rr_after;
  logic [3:0] others;
  logic [2:0] pick_idle;
  logic [2:0] pick_next;

  assign hold_done = (state_q == S_HOLD) && (cnt_q == CNT_LAST);
  assign owner_req = req_ext[owner_q];
  assign rr_after  = (owner_q == LAST_IDX) ? 2'd0 : owner_q + 2'd1;
  // At the end of a hold, the current owner is excluded from the scan.
  // Any other requester takes precedence over an owner extension.
  assign others    = req_ext & ~(4'b0001 << owner_q);
  assign pick_idle = rr_pick(req_ext, rr_q);
  assign pick_next = rr_pick(others, rr_after);

  // ---------------------------------------------------------------------------
  // State register (plus the datapath registers it steers)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rr_q    <= 2'd0;
      owner_q <= 2'd0;
      dig_q   <= 32'h0;
      blank_q <= 8'h00;
      ack_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      owner_q <= owner_d;
      dig_q   <= dig_d;
      blank_q <= blank_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pick_idle[2]) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        // Leave only when the hold has expired and nobody wants the display.
        if (hold_done && !pick_next[2] && !owner_req) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // ---------------------------------------------------------------------------
  logic       grant;
  logic [1:0] grant_idx;
  logic [3:0] grant_onehot;

  always_comb begin
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    dig_d     = dig_q;
    ack_d     = '0;
    valid_d   = valid_q;
    grant     = 1'b0;
    grant_idx = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (pick_idle[2]) begin
          grant     = 1'b1;
          grant_idx = pick_idle[1:0];
        end
      end
      S_HOLD: begin
        if (!hold_done) begin
          cnt_d = cnt_q + CW'(1);
          // Live update while the owner keeps requesting.
          // Once the owner drops its request, the last word is frozen.
          if (owner_req) begin
            dig_d = word[owner_q];
          end
        end else begin
          rr_d = rr_after;
          if (pick_next[2]) begin
            grant     = 1'b1;
            grant_idx = pick_next[1:0];
          end else if (owner_req) begin
            cnt_d = '0;
            dig_d = word[owner_q];
          end
          // Otherwise the FSM drops to IDLE and dig/owner keep their values.
        end
      end
      default: ;
    endcase

    grant_onehot = 4'b0001 << grant_idx;
    if (grant) begin
      owner_d = grant_idx;
      dig_d   = word[grant_idx];
      ack_d   = grant_onehot[NREQ-1:0];
      valid_d = 1'b1;
      cnt_d   = '0;
    end
  end

  // Leading-zero mask, computed from the word about to be registered so that
  // blank_o lines up with dig_o. zero_from[k] is 1 when digits 7..k are all
  // zero. Digit 0 is never blanked, so a zero word still shows a single "0".
  logic [8:1] zero_from;
  assign zero_from[8] = 1'b1;

  generate
    for (gi = 1; gi < 8; gi++) begin : g_lzb
      assign zero_from[gi] = zero_from[gi+1] & (dig_d[4*gi +: 4] == 4'h0);
      assign blank_d[gi]   = lzb_i & zero_from[gi];
    end
  endgenerate
  assign blank_d[0] = 1'b0;

  assign ack_o   = ack_q;
  assign owner_o = owner_q;
  assign valid_o = valid_q;
  assign dig_o   = dig_q;
  assign blank_o = blank_q;

endmodule

// File: tb/tb_seg7_disp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seg7_disp_arbiter
//
// Self-checking bench for seg7_disp_arbiter with NREQ=2 and HOLD_CYC=4.
// Each stimulus cycle advances a behavioural model of the arbiter. The model
// tracks owner, cycles left and pointer, and pushes the expected outputs into
// a queue. A separate monitor pops one entry after every clock edge and
// compares it with the DUT.
// -----------------------------------------------------------------------------
module tb_seg7_disp_arbiter;

  localparam int NREQ = 2;
  localparam int HOLD = 4;
  localparam int CW   = 26;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req   = 2'b00;
  logic [63:0]     data  = 64'h0;
  logic            lzb   = 1'b0;
  logic [1:0]      ack;
  logic [1:0]      owner;
  logic            valid;
  logic [31:0]     dig;
  logic [7:0]      blank;

  seg7_disp_arbiter #(
    .NREQ(NREQ), .HOLD_CYC(HOLD), .CW(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .data_i(data), .lzb_i(lzb),
    .ack_o(ack), .owner_o(owner), .valid_o(valid), .dig_o(dig), .blank_o(blank)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  ack;
    logic [1:0]  owner;
    logic        valid;
    logic [31:0] dig;
    logic [7:0]  blank;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit          m_busy;
  int          m_owner;
  int          m_left;   // edges still to go in the current grant, incl. the final one
  int          m_ptr;
  logic [31:0] m_dig;
  bit          m_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int scan(input logic [1:0] r, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (r[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  // Count the leading zero digits; digits 7..k all zero iff k >= 8 - lz.
  function automatic logic [7:0] blank_of(input logic [31:0] w, input logic en);
    logic [7:0] b;
    int lz;
    b  = 8'h00;
    lz = 0;
    if (!en) return b;
    for (int d = 7; d >= 0; d--) begin
      if (w[4*d +: 4] != 4'h0) break;
      lz++;
    end
    for (int k = 1; k < 8; k++) b[k] = (k >= 8 - lz);
    return b;
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_owner = 0;
    m_left  = 0;
    m_ptr   = 0;
    m_dig   = 32'h0;
    m_valid = 0;
  endtask

  task automatic model_step(input logic [1:0] r, input logic [63:0] d,
                            input logic l, output exp_t e);
    logic [1:0] a;
    int w;
    a = 2'b00;
    w = -1;
    if (!m_busy) begin
      w = scan(r, m_ptr);
    end else if (m_left > 1) begin
      m_left--;
      if (r[m_owner]) m_dig = d[32*m_owner +: 32];
    end else begin
      m_ptr = (m_owner + 1) % NREQ;
      w = scan(r & ~(2'b01 << m_owner), m_ptr);
      if (w < 0) begin
        if (r[m_owner]) begin
          m_left = HOLD;
          m_dig  = d[32*m_owner +: 32];
        end else begin
          m_busy = 0;
        end
      end
    end
    if (w >= 0) begin
      m_owner = w;
      m_dig   = d[32*w +: 32];
      a       = 2'b01 << w;
      m_valid = 1;
      m_busy  = 1;
      m_left  = HOLD;
    end
    e.ack   = a;
    e.owner = 2'(m_owner);
    e.valid = m_valid;
    e.dig   = m_dig;
    e.blank = blank_of(m_dig, l);
  endtask

  // One clock: drive inputs on the falling edge, queue the expectation for the
  // following rising edge, then let that edge happen.
  task automatic cycle(input logic [1:0] r, input logic [31:0] d0,
                       input logic [31:0] d1, input logic l);
    exp_t e;
    @(negedge clk);
    rst_n = 1'b1;
    req   = r;
    data  = {d1, d0};
    lzb   = l;
    model_step(r, {d1, d0}, l, e);
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Assert reset away from any clock edge. The outputs must clear at once,
  // before the next rising edge. Reset is held across one rising edge, and
  // the next cycle() releases it.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_dig",   dig,   32'h0);
    chk("rst_blank", 32'(blank), 32'h0);
    chk("rst_ack",   32'(ack),   32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    model_reset();
    @(posedge clk);
  endtask

  // Monitor: one expectation per clocked cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ack",   32'(ack),   32'(e.ack));
        chk("owner", 32'(owner), 32'(e.owner));
        chk("valid", 32'(valid), 32'(e.valid));
        chk("dig",   dig,        e.dig);
        chk("blank", 32'(blank), 32'(e.blank));
        if (ack != 2'b00)
          $display("grant: ack=%b owner=%0d dig=%h blank=%b", ack, owner, dig, blank);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int sh;
    w  = $urandom;
    sh = $urandom_range(0, 8);
    return (sh == 8) ? 32'h0 : (w >> (4 * sh));
  endfunction

  initial begin
    model_reset();
    do_reset();

    // Single requester, then it drops its request and the hold runs out.
    cycle(2'b01, 32'h12345678, 32'hDEADBEEF, 1'b0);
    repeat (6) cycle(2'b00, 32'h0, 32'h0, 1'b0);

    // Contention: both request continuously, so ownership alternates with no idle gap.
    repeat (12) cycle(2'b11, 32'hA0A0A0A0, 32'hB1B1B1B1, 1'b0);
    repeat (6) cycle(2'b00, 32'h0, 32'h0, 1'b0);

    // Live update while the owner holds its request.
    do_reset();
    cycle(2'b01, 32'h1, 32'h9, 1'b0);
    cycle(2'b01, 32'h1, 32'h9, 1'b0);
    repeat (3) cycle(2'b01, 32'h2, 32'h9, 1'b0);

    // Leading-zero blanking; lzb changes take effect even in IDLE.
    cycle(2'b01, 32'h00000A05, 32'h0, 1'b1);
    cycle(2'b01, 32'h00000000, 32'h0, 1'b1);
    cycle(2'b01, 32'h00000A05, 32'h0, 1'b0);
    repeat (6) cycle(2'b00, 32'h0, 32'h0, 1'b0);
    cycle(2'b00, 32'h0, 32'h0, 1'b1);

    // Reset in mid-hold, then req1 wins after release.
    cycle(2'b01, 32'h55, 32'h66, 1'b0);
    repeat (2) cycle(2'b01, 32'h55, 32'h66, 1'b0);
    do_reset();
    repeat (3) cycle(2'b10, 32'h55, 32'h66, 1'b0);
    repeat (6) cycle(2'b00, 32'h0, 32'h0, 1'b0);

    // Early drop: the owner releases early, and nobody else is granted before the hold ends.
    do_reset();
    cycle(2'b01, 32'hC0, 32'hC1, 1'b0);
    repeat (6) cycle(2'b10, 32'hC0, 32'hC1, 1'b0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      cycle(2'($urandom), rand_word(), rand_word(), ($urandom_range(0, 3) != 0));
    end

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
